// File: rtl/alu_arbiter.sv
// Round-robin arbiter/sequencer sharing one ALU between two requesters.
// Optional feature: define ALU_ARB_STICKY_EN to accumulate captured {O,Ca} on sticky.
module alu_arbiter #(
  parameter int unsigned N   = 5,
  parameter int unsigned LAT = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         req0,
  input  logic         req1,
  input  logic [3:0]   op0,
  input  logic [3:0]   op1,
  input  logic [N-1:0] a0,
  input  logic [N-1:0] b0,
  input  logic [N-1:0] a1,
  input  logic [N-1:0] b1,
  output logic         gnt0,
  output logic         gnt1,
  output logic         done0,
  output logic         done1,
  output logic [N-1:0] res,
  output logic [3:0]   flags,
  output logic         err,
  output logic [3:0]   alu_sel,
  output logic [N-1:0] alu_a,
  output logic [N-1:0] alu_b,
  input  logic [N-1:0] alu_res,
  input  logic         alu_neg,
  input  logic         alu_z,
  input  logic         alu_o,
  input  logic         alu_ca,
  output logic [1:0]   sticky,
  input  logic         sticky_clr
);

  localparam int unsigned CW     = (LAT > 1) ? $clog2(LAT) : 1;
  localparam logic [3:0]  OP_MAX = 4'd11;

  typedef enum logic [1:0] {IDLE, ISSUE, DONE} state_t;

  state_t         state;
  logic           last;
  logic           port;
  logic [CW-1:0]  cnt;

  logic           pending;
  logic           pick;
  logic [3:0]     pick_op;
  logic [N-1:0]   pick_a;
  logic [N-1:0]   pick_b;
  logic           cap;

  // Round-robin choice: on a tie the port that did not win last time goes.
  always_comb begin
    pending = req0 | req1;
    pick    = (req0 && req1) ? ~last : req1;
    pick_op = pick ? op1 : op0;
    pick_a  = pick ? a1 : a0;
    pick_b  = pick ? b1 : b0;
  end

  assign cap = (state == ISSUE) && (cnt == CW'(LAT - 1));

  // alu_sel/alu_a/alu_b double as the operand latch; they are only nonzero in ISSUE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      last    <= 1'b1;
      port    <= 1'b0;
      cnt     <= '0;
      gnt0    <= 1'b0;
      gnt1    <= 1'b0;
      done0   <= 1'b0;
      done1   <= 1'b0;
      res     <= '0;
      flags   <= '0;
      err     <= 1'b0;
      alu_sel <= '0;
      alu_a   <= '0;
      alu_b   <= '0;
    end else begin
      gnt0  <= 1'b0;
      gnt1  <= 1'b0;
      done0 <= 1'b0;
      done1 <= 1'b0;
      case (state)
        IDLE: begin
          if (pending) begin
            port <= pick;
            last <= pick;
            gnt0 <= ~pick;
            gnt1 <= pick;
            if (pick_op > OP_MAX) begin
              // Illegal op bypasses the ALU entirely.
              res   <= '0;
              flags <= '0;
              err   <= 1'b1;
              done0 <= ~pick;
              done1 <= pick;
              state <= DONE;
            end else begin
              alu_sel <= pick_op;
              alu_a   <= pick_a;
              alu_b   <= pick_b;
              cnt     <= '0;
              state   <= ISSUE;
            end
          end
        end
        ISSUE: begin
          if (cap) begin
            res     <= alu_res;
            flags   <= {alu_neg, alu_z, alu_o, alu_ca};
            err     <= 1'b0;
            alu_sel <= '0;
            alu_a   <= '0;
            alu_b   <= '0;
            cnt     <= '0;
            done0   <= ~port;
            done1   <= port;
            state   <= DONE;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

`ifdef ALU_ARB_STICKY_EN
  // Clear drops old bits only; flags captured on the same edge still land.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sticky <= 2'b00;
    end else begin
      sticky <= (sticky_clr ? 2'b00 : sticky) | (cap ? {alu_o, alu_ca} : 2'b00);
    end
  end
`else
  logic unused_sticky_clr;
  assign unused_sticky_clr = sticky_clr;
  assign sticky = 2'b00;
`endif

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Two-port arbiter and sequencer for the shared ALU/flags datapath of the image decryptor. Two requesters (key-schedule engine and pixel-decrypt engine) issue single ALU operations through a req/gnt/done handshake. The block grants the ALU round-robin, holds operands and `sel` stable for the ALU latency, and returns the captured result and flags {Neg,Z,O,Ca} to the winning requester.

## Interface
- `N`, 5, ALU operand/result width.
- `LAT`, 1, cycles the ALU needs from stable inputs to valid result/flags (≥1).
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: reset, asynchronous assert, active-low. One clock, asynchronous active-low reset.
- `req0`, `req1` in 1: request per port; held high with op/operands stable until `done` of that port.
- `op0`, `op1` in 4: ALU select code; legal codes are 0–11.
- `a0`, `b0`, `a1`, `b1` in N: operands.
- `gnt0`, `gnt1` out 1: one-cycle pulse when the port's request is accepted.
- `done0`, `done1` out 1: one-cycle pulse; `res`/`flags`/`err` are valid in that cycle.
- `res` out N: result; `flags` out 4: {Neg,Z,O,Ca}; `err` out 1: illegal op.
- `alu_sel` out 4, `alu_a` out N, `alu_b` out N: drive the ALU.
- `alu_res` in N, `alu_neg`/`alu_z`/`alu_o`/`alu_ca` in 1: ALU outputs.
- `sticky` out 2: {O,Ca} accumulated; `sticky_clr` in 1: clears `sticky`.

## Operation
- FSM states: IDLE, ISSUE, DONE.
- IDLE: if no request is pending, stay in IDLE. If exactly one request is pending, choose it. If both are pending, choose the port that is not `last`; `last` resets to 1, so port 0 wins the first tie. On choosing, latch port id, op, a and b; set `gnt` of the chosen port for the next cycle; update `last`; go to ISSUE.
- ISSUE: drive `alu_sel`/`alu_a`/`alu_b` from the latched registers. Count LAT cycles. On the edge ending the last count, capture `alu_res` and the four flags into `res`/`flags`, then go to DONE.
- Illegal op (12–15): skip the ALU and go from IDLE straight to DONE with `res`=0, `flags`=0, `err`=1. `gnt` still pulses.
- DONE: pulse the chosen port's `done` for one cycle, then return to IDLE. Requests are sampled only in IDLE.
- The requester drops `req` at the edge ending its `done` cycle. A `req` still high in the following IDLE cycle is a new request.
- Outside ISSUE, `alu_sel`/`alu_a`/`alu_b` = 0.
- `res`, `flags` and `err` hold their last value until the next capture.
- Reset values (async): state IDLE; all outputs 0; `last`=1; counter 0.
- Reset mid-operation: the operation is aborted; no `done` is ever issued for it. Requesters restart after reset.
- Changes on `req` or operands of a port while it is being serviced are ignored, because values are latched at grant.

## Timing
- `req` sampled high in IDLE at cycle t → `gnt` high in cycle t+1, ALU driven in cycles t+1..t+LAT → `done` in cycle t+LAT+1.
- With LAT=1: grant at t+1, done at t+2.
- Illegal op: `gnt` and `done` both in cycle t+1.
- Minimum request-to-request period per arbiter: LAT+2 cycles.
- Under contention, each port waits at most one other operation (LAT+2 cycles) before grant.
- `sticky` updates at the DONE-entry edge. If `sticky_clr` and an update coincide, the clear wins for old bits; new O/Ca from that operation are still set.

## Configuration
- `ALU_ARB_STICKY_EN` defined: `sticky` = OR-accumulation of captured {O,Ca} since reset or the last `sticky_clr`.
- `ALU_ARB_STICKY_EN` undefined: `sticky` is tied to 2'b00 and `sticky_clr` is ignored. The ports exist in both builds.

## Test plan
Parameters N=5, LAT=1; the bench ALU model uses the team's flag rules.
- `req0` op 0 (add), a=15, b=1 → `gnt0` at cycle 1, `done0` at cycle 2; `res`=16, `flags`=4'b1010 (Neg, O); `err`=0.
- `req1` op 1 (sub), a=3, b=3 → `done1`; `res`=0, `flags`=4'b0100 (Z).
- `req0` and `req1` both asserted from reset, each held until its own done → port 0 granted first, then port 1 granted in the IDLE cycle after `done0`; no cycle with both `gnt`s high; alternation continues while both stay asserted.
- `req0` op 13 → `gnt0` and `done0` in the same cycle after sampling; `err`=1, `res`=0; `alu_sel` remains 0 throughout.
- `rst_n` pulled low during ISSUE of a port-1 op → all outputs 0 immediately; no `done1` after release; next tie grants port 0.
- With `ALU_ARB_STICKY_EN`: the add from the first scenario, then `sticky_clr` for 1 cycle → `sticky`=2'b10, then 2'b00. Without the macro, `sticky` is always 0.
